// File: rtl/sdcard_writeback.sv
// Streams WORD_COUNT 64-bit RAM words to an SdCardCtrl instance as zero-padded 512-byte blocks.
// Defining SDCARD_WRITEBACK_CHECKSUM_EN adds a wrapping byte-sum of every non-pad byte accepted.
module sdcard_writeback #(
    parameter logic [24:0] WORD_COUNT = 25'h250000,
    parameter logic        SDHC       = 1'b1
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        start,
    output logic        ram_re,
    output logic [20:0] ram_address,
    input  logic [63:0] ram_rdata,
    input  logic        ram_data_valid,
    output logic        sd_wr,
    output logic        sd_continue,
    output logic [31:0] sd_addr,
    output logic [7:0]  sd_wdata,
    output logic        sd_hndshk_out,
    input  logic        sd_hndshk_in,
    input  logic        sd_busy,
    input  logic [15:0] sd_error,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum
);

    typedef enum logic [3:0] {
        WAIT_INIT,
        IDLE,
        BLK_START,
        RAM_REQ,
        BYTE_OFFER,
        BYTE_RELEASE,
        BLK_END,
        DONE,
        ERROR
    } state_t;

    // One spare bit so padding the final block can never wrap the word counter.
    localparam logic [25:0] WordLimit = {1'b0, WORD_COUNT};

    state_t      state_q, state_d;
    logic [25:0] wordCnt_q, wordCnt_d;
    logic [8:0]  byteCnt_q, byteCnt_d;
    logic [63:0] dataWord_q, dataWord_d;

    logic        wordsLeft;
    logic        runStart;
    logic        byteAccept;
    logic [5:0]  byteShift;
    logic [7:0]  curByte;

    assign wordsLeft  = wordCnt_q < WordLimit;
    assign runStart   = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign byteAccept = (state_q == BYTE_OFFER) && sd_hndshk_in;
    assign byteShift  = {3'd7 - byteCnt_q[2:0], 3'b000};
    assign curByte    = 8'(dataWord_q >> byteShift);

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q    <= WAIT_INIT;
            wordCnt_q  <= '0;
            byteCnt_q  <= '0;
            dataWord_q <= '0;
        end else begin
            state_q    <= state_d;
            wordCnt_q  <= wordCnt_d;
            byteCnt_q  <= byteCnt_d;
            dataWord_q <= dataWord_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wordCnt_d  = wordCnt_q;
        byteCnt_d  = byteCnt_q;
        dataWord_d = dataWord_q;
        case (state_q)
            WAIT_INIT: begin
                if (!sd_busy) begin
                    state_d = (sd_error == 16'h0000) ? IDLE : ERROR;
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    wordCnt_d = '0;
                    state_d   = (WORD_COUNT == 25'd0) ? DONE : BLK_START;
                end
            end
            BLK_START: begin
                if (sd_busy) begin
                    byteCnt_d = '0;
                    state_d   = RAM_REQ;
                end
            end
            RAM_REQ: begin
                if (!wordsLeft) begin
                    dataWord_d = '0;
                    state_d    = BYTE_OFFER;
                end else if (ram_data_valid) begin
                    dataWord_d = ram_rdata;
                    state_d    = BYTE_OFFER;
                end
            end
            BYTE_OFFER: begin
                if (sd_hndshk_in) begin
                    state_d = BYTE_RELEASE;
                end
            end
            BYTE_RELEASE: begin
                if (!sd_hndshk_in) begin
                    byteCnt_d = byteCnt_q + 9'd1;
                    if (byteCnt_q[2:0] == 3'd7) begin
                        wordCnt_d = wordCnt_q + 26'd1;
                    end
                    if (byteCnt_q == 9'd511) begin
                        state_d = BLK_END;
                    end else if (byteCnt_q[2:0] == 3'd7) begin
                        state_d = RAM_REQ;
                    end else begin
                        state_d = BYTE_OFFER;
                    end
                end
            end
            BLK_END: begin
                if (!sd_busy) begin
                    if (sd_error != 16'h0000) begin
                        state_d = ERROR;
                    end else if (!wordsLeft) begin
                        state_d = DONE;
                    end else begin
                        state_d = BLK_START;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = WAIT_INIT;
            end
        endcase
    end

    // Outputs are forced low while reset is held so an abandoned block sees no further edges.
    always_comb begin
        ram_re        = 1'b0;
        ram_address   = '0;
        sd_wr         = 1'b0;
        sd_continue   = 1'b0;
        sd_addr       = '0;
        sd_wdata      = '0;
        sd_hndshk_out = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        error         = 1'b0;
        if (!reset) begin
            ram_address = wordCnt_q[20:0];
            sd_addr     = SDHC ? {12'b0, wordCnt_q[25:6]} : {3'b0, wordCnt_q, 3'b000};
            case (state_q)
                BLK_START: begin
                    sd_wr = 1'b1;
                    busy  = 1'b1;
                end
                RAM_REQ: begin
                    ram_re = wordsLeft;
                    busy   = 1'b1;
                end
                BYTE_OFFER: begin
                    sd_hndshk_out = 1'b1;
                    sd_wdata      = curByte;
                    busy          = 1'b1;
                end
                BYTE_RELEASE, BLK_END: begin
                    busy = 1'b1;
                end
                DONE: begin
                    done = 1'b1;
                end
                ERROR: begin
                    error = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

`ifdef SDCARD_WRITEBACK_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Pad bytes are recognised by the word counter having passed the requested word count.
    always_comb begin
        checksum_d = checksum_q;
        if (runStart) begin
            checksum_d = '0;
        end else if (byteAccept && wordsLeft) begin
            checksum_d = checksum_q + {24'b0, curByte};
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = reset ? 32'h0 : checksum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_sdcard_writeback.sv
// Self-checking bench for sdcard_writeback: scenario table plus a mid-run reset sequence,
// with behavioural RAM and SD controller models and a byte-stream reference model.
module tb_sdcard_writeback;

    localparam int WORDS    = 70;
    localparam int INIT_LEN = 5;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ram_re;
    logic [20:0] ram_address;
    logic [63:0] ram_rdata = '0;
    logic        ram_data_valid = 1'b0;
    logic        sd_wr, sd_continue;
    logic [31:0] sd_addr;
    logic [7:0]  sd_wdata;
    logic        sd_hndshk_out;
    logic        sd_hndshk_in = 1'b0;
    logic        sd_busy = 1'b1;
    logic [15:0] sd_error = '0;
    logic        busy, done, error;
    logic [31:0] checksum;

    logic        zRamRe, zSdWr, zSdCont, zHsOut, zBusy, zDone, zError;
    logic [20:0] zRamAddr;
    logic [31:0] zSdAddr, zChecksum;
    logic [7:0]  zSdWdata;

    typedef struct {
        logic [15:0] initErr;
        int          errBlk;
        bit          randData;
        int          maxDelay;
        bit          expDone;
        bit          expError;
        int          expBlocks;
    } vec_t;

    vec_t        vecs[4];
    logic [63:0] ramMem[0:127];
    logic [7:0]  byteLog[$];
    logic [31:0] addrLog[$];
    logic [20:0] reqLog[$];
    logic [15:0] initErr = '0;
    int errBlk = -1, maxDelay = 0, stableErr = 0;
    int wrRises = 0, zWrRises = 0, hsRises = 0;
    int nChecks = 0, nFails = 0;
    logic prevWr = 1'b0, prevZWr = 1'b0, prevHs = 1'b0;

    always #10 clk50 = ~clk50;

    sdcard_writeback #(.WORD_COUNT(25'd70), .SDHC(1'b1)) dut (
        .clk50(clk50), .reset(reset), .start(start),
        .ram_re(ram_re), .ram_address(ram_address), .ram_rdata(ram_rdata),
        .ram_data_valid(ram_data_valid),
        .sd_wr(sd_wr), .sd_continue(sd_continue), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
        .sd_hndshk_out(sd_hndshk_out), .sd_hndshk_in(sd_hndshk_in), .sd_busy(sd_busy),
        .sd_error(sd_error), .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    sdcard_writeback #(.WORD_COUNT(25'd0), .SDHC(1'b0)) dutZero (
        .clk50(clk50), .reset(reset), .start(start),
        .ram_re(zRamRe), .ram_address(zRamAddr), .ram_rdata(64'h0), .ram_data_valid(1'b0),
        .sd_wr(zSdWr), .sd_continue(zSdCont), .sd_addr(zSdAddr), .sd_wdata(zSdWdata),
        .sd_hndshk_out(zHsOut), .sd_hndshk_in(1'b0), .sd_busy(1'b0),
        .sd_error(16'h0000), .busy(zBusy), .done(zDone), .error(zError), .checksum(zChecksum)
    );

    // RAM model: answers each read after a random 0..3 cycle latency and logs the address served.
    initial begin
        int ramWait;
        ramWait = 0;
        forever begin
            @(negedge clk50);
            if (reset) begin
                ram_data_valid = 1'b0;
                ramWait = 0;
            end else if (ram_data_valid) begin
                ram_data_valid = 1'b0;
            end else if (ram_re) begin
                if (ramWait == 0) begin
                    ram_data_valid = 1'b1;
                    ram_rdata = ramMem[ram_address[6:0]];
                    reqLog.push_back(ram_address);
                    ramWait = $urandom_range(0, 3);
                end else begin
                    ramWait--;
                end
            end
        end
    end

    // SD controller model: busy during init, then one block per sd_wr with random handshake delay.
    initial begin
        int initCnt, hsWait, blkBytes, tail, blkIdx;
        logic inBlock;
        logic [7:0] heldByte;
        initCnt = 0; hsWait = -1; blkBytes = 0; tail = -1; blkIdx = 0;
        inBlock = 1'b0; heldByte = '0;
        forever begin
            @(negedge clk50);
            if (reset) begin
                sd_busy = 1'b1; sd_error = '0; sd_hndshk_in = 1'b0;
                initCnt = INIT_LEN; inBlock = 1'b0; hsWait = -1; tail = -1; blkIdx = 0;
            end else if (initCnt > 0) begin
                initCnt--;
                if (initCnt == 0) begin
                    sd_busy = 1'b0;
                    sd_error = initErr;
                end
            end else if (!inBlock) begin
                if (sd_wr && !sd_busy && sd_error == 16'h0000) begin
                    sd_busy = 1'b1; inBlock = 1'b1; blkBytes = 0; tail = -1;
                    addrLog.push_back(sd_addr);
                end
            end else if (sd_hndshk_in) begin
                if (!sd_hndshk_out) sd_hndshk_in = 1'b0;
            end else if (sd_hndshk_out) begin
                if (hsWait < 0) begin
                    hsWait = $urandom_range(0, maxDelay);
                    heldByte = sd_wdata;
                end else if (sd_wdata !== heldByte) begin
                    stableErr++;
                end
                if (hsWait == 0) begin
                    sd_hndshk_in = 1'b1;
                    byteLog.push_back(heldByte);
                    blkBytes++;
                    hsWait = -1;
                end else begin
                    hsWait--;
                end
            end else if (blkBytes == 512) begin
                if (tail < 0) begin
                    tail = 3;
                end else if (tail == 0) begin
                    sd_busy = 1'b0;
                    inBlock = 1'b0;
                    if (blkIdx == errBlk) sd_error = 16'h0010;
                    blkIdx++;
                end else begin
                    tail--;
                end
            end
        end
    end

    always @(negedge clk50) begin
        if (sd_wr && !prevWr) wrRises++;
        if (zSdWr && !prevZWr) zWrRises++;
        if (sd_hndshk_out && !prevHs) hsRises++;
        prevWr = sd_wr;
        prevZWr = zSdWr;
        prevHs = sd_hndshk_out;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference byte stream: words in order, MSB byte first, words past the count read as zero.
    function automatic logic [7:0] expByte(input int idx);
        logic [63:0] word;
        int w, k;
        w = idx / 8;
        k = idx % 8;
        word = (w < WORDS) ? ramMem[w] : 64'h0;
        return word[(7 - k) * 8 +: 8];
    endfunction

    task automatic doReset();
        @(negedge clk50);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk50);
        checkOutput("rstCtrl", 64'({ram_re, ram_address, sd_wr, sd_continue, sd_wdata,
                                    sd_hndshk_out, busy, done, error}), 64'h0);
        checkOutput("rstAddrSum", {sd_addr, checksum}, 64'h0);
        byteLog.delete(); addrLog.delete(); reqLog.delete();
        stableErr = 0; wrRises = 0; zWrRises = 0; hsRises = 0;
        reset = 1'b0;
        repeat (INIT_LEN + 6) @(negedge clk50);
    endtask

    task automatic pulseStart();
        @(negedge clk50);
        start = 1'b1;
        @(negedge clk50);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        initErr = v.initErr;
        errBlk = v.errBlk;
        maxDelay = v.maxDelay;
        for (int i = 0; i < 128; i++) begin
            logic [7:0] b;
            b = 8'(i);
            ramMem[i] = v.randData ? {$urandom, $urandom} : {8{b}};
        end
        doReset();
        pulseStart();
        for (int c = 0; c < 40000 && !(done || error); c++) @(negedge clk50);
        if (v.expError) begin
            pulseStart();
            repeat (100) @(negedge clk50);
        end
    endtask

    initial begin
        vecs[0] = '{16'h0000, -1, 1'b0, 0, 1'b1, 1'b0, 2};
        vecs[1] = '{16'h0000, -1, 1'b1, 20, 1'b1, 1'b0, 2};
        vecs[2] = '{16'h0004, -1, 1'b1, 3, 1'b0, 1'b1, 0};
        vecs[3] = '{16'h0000, 0, 1'b1, 5, 1'b0, 1'b1, 1};

        for (int i = 0; i < 4; i++) begin
            int bad, expWords;
            logic [31:0] expSum;
            applyStimulus(vecs[i]);
            $display("[TB] scenario %0d", i);
            checkOutput("done", 64'(done), 64'(vecs[i].expDone));
            checkOutput("error", 64'(error), 64'(vecs[i].expError));
            checkOutput("busyIdle", 64'(busy), 64'h0);
            checkOutput("sdContinue", 64'(sd_continue), 64'h0);
            checkOutput("wrCount", 64'(wrRises), 64'(vecs[i].expBlocks));
            checkOutput("blkCount", 64'(addrLog.size()), 64'(vecs[i].expBlocks));
            for (int b = 0; b < addrLog.size() && b < vecs[i].expBlocks; b++)
                checkOutput("blkAddr", 64'(addrLog[b]), 64'(b));
            checkOutput("byteCount", 64'(byteLog.size()), 64'(vecs[i].expBlocks * 512));
            bad = 0;
            for (int n = 0; n < byteLog.size() && n < vecs[i].expBlocks * 512; n++)
                if (byteLog[n] !== expByte(n)) bad++;
            checkOutput("byteStream", 64'(bad), 64'h0);
            expWords = (vecs[i].expBlocks * 64 < WORDS) ? vecs[i].expBlocks * 64 : WORDS;
            checkOutput("ramReqCount", 64'(reqLog.size()), 64'(expWords));
            bad = 0;
            for (int n = 0; n < reqLog.size(); n++)
                if (reqLog[n] !== 21'(n)) bad++;
            checkOutput("ramReqOrder", 64'(bad), 64'h0);
            checkOutput("wdataStable", 64'(stableErr), 64'h0);
            expSum = '0;
`ifdef SDCARD_WRITEBACK_CHECKSUM_EN
            for (int n = 0; n < vecs[i].expBlocks * 512; n++)
                if (n / 8 < WORDS) expSum = expSum + {24'b0, expByte(n)};
`endif
            checkOutput("checksum", 64'(checksum), 64'(expSum));
            checkOutput("zeroDone", 64'(zDone), 64'h1);
            checkOutput("zeroWr", 64'(zWrRises), 64'h0);
            checkOutput("zeroCtrl", 64'({zRamRe, zRamAddr, zSdWr, zSdCont, zSdWdata,
                                         zHsOut, zBusy, zError}), 64'h0);
            checkOutput("zeroAddrSum", {zSdAddr, zChecksum}, 64'h0);
        end

        // Mid-block reset: abandon the run while a byte is on offer.
        begin
            bit reached;
            initErr = '0; errBlk = -1; maxDelay = 4;
            doReset();
            pulseStart();
            reached = 1'b0;
            for (int c = 0; c < 20000 && !reached; c++) begin
                @(negedge clk50);
                if (byteLog.size() >= 100 && sd_hndshk_out) reached = 1'b1;
            end
            checkOutput("midRunReached", 64'(reached), 64'h1);
            reset = 1'b1;
            @(posedge clk50);
            #1;
            checkOutput("midRstCtrl", 64'({ram_re, sd_wr, sd_wdata, sd_hndshk_out, busy, done, error}), 64'h0);
            checkOutput("midRstAddrSum", {sd_addr, checksum}, 64'h0);
            repeat (2) @(negedge clk50);
            hsRises = 0; wrRises = 0;
            reset = 1'b0;
            repeat (30) @(negedge clk50);
            checkOutput("postRstHandshake", 64'(hsRises + wrRises), 64'h0);
            checkOutput("postRstState", 64'({busy, done, error}), 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
